// File: rtl/obi_mem_model.sv
`default_nettype none
// obi_mem_model: OBI-style memory model with pipelined in-order responses,
// random grant/response wait states and address-qualified error injection. Rev 1.0
module obi_mem_model #(
  parameter int          AW_MEM       = 16,
  parameter int          DW           = 32,
  parameter int          MAX_OUTST    = 4,
  parameter logic [31:0] KEEPOUT_BASE = 32'h8000_0000,
  parameter logic [31:0] KEEPOUT_TOP  = 32'h8000_01ff
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      ERR_RATE,
  input  logic [3:0]      GNT_WMAX,
  input  logic [3:0]      RESP_WMAX,
  input  logic            err_enable,
  input  logic            req,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [31:0]     addr,
  input  logic [DW-1:0]   wdata,
  output logic            gnt,
  output logic            rvalid,
  output logic [DW-1:0]   rdata,
  output logic            err
);

  localparam int BW  = DW / 8;
  localparam int OFS = (BW > 1) ? $clog2(BW) : 0;
  localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW  = $clog2(MAX_OUTST + 1);

  // Backing store; left unreset so contents survive rst_n and can be preloaded.
  reg [DW-1:0] mem [0:(1<<AW_MEM)-1];

  logic [DW:0]       fifo_q [MAX_OUTST];
  logic [31:0]       rnd_gnt_q;
  logic [31:0]       rnd_rsp_q;
  logic [8:0]        rnd_err_q;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [3:0]        rcnt_q, rcnt_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [AW_MEM-1:0] widx;
  logic              in_keepout;
  logic [8:0]        err_mask;
  logic              err_hit;
  logic [DW-1:0]     push_data;

  assign widx       = addr[AW_MEM+OFS-1:OFS];
  assign in_keepout = (addr >= KEEPOUT_BASE) && (addr <= KEEPOUT_TOP);
  // Low (8-ERR_RATE) random bits all zero gives probability 2^-(8-ERR_RATE).
  assign err_mask   = (9'd1 << (4'd8 - {1'b0, ERR_RATE})) - 9'd1;
  assign err_hit    = err_enable && (ERR_RATE != 3'd0) &&
                      ((rnd_err_q & err_mask) == 9'd0) && !in_keepout;

  assign gnt       = rst_n && req && (gcnt_q == 4'd0) && (count_q < CW'(MAX_OUTST));
  assign rvalid    = (count_q != '0) && (rcnt_q == 4'd0);
  assign rdata     = rvalid ? fifo_q[rptr_q][DW-1:0] : '0;
  assign err       = rvalid & fifo_q[rptr_q][DW];
  assign push_data = (!we && !err_hit) ? mem[widx] : '0;

  always_comb begin
    gcnt_d  = gcnt_q;
    rcnt_d  = rcnt_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;

    if (gnt) begin
      gcnt_d = 4'(rnd_gnt_q % (32'(GNT_WMAX) + 32'd1));
      wptr_d = (wptr_q == PW'(MAX_OUTST - 1)) ? '0 : wptr_q + PW'(1);
    end else if (gcnt_q != 4'd0) begin
      gcnt_d = gcnt_q - 4'd1;
    end

    if (rvalid) begin
      rcnt_d = 4'(rnd_rsp_q % (32'(RESP_WMAX) + 32'd1));
      rptr_d = (rptr_q == PW'(MAX_OUTST - 1)) ? '0 : rptr_q + PW'(1);
    end else if ((rcnt_q != 4'd0) && (count_q != '0)) begin
      rcnt_d = rcnt_q - 4'd1;
    end

    if (gnt && !rvalid) begin
      count_d = count_q + CW'(1);
    end else if (!gnt && rvalid) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q  <= 4'd0;
      rcnt_q  <= 4'd0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      gcnt_q  <= gcnt_d;
      rcnt_q  <= rcnt_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Fresh random draws every cycle; consumed by the reloads and the error draw.
  always_ff @(posedge clk) begin
    rnd_gnt_q <= $urandom;
    rnd_rsp_q <= $urandom;
    rnd_err_q <= 9'($urandom);
  end

  always_ff @(posedge clk) begin
    if (gnt) begin
      fifo_q[wptr_q] <= {err_hit, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (gnt && we && !err_hit) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) begin
          mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_mem_model.sv
`default_nettype none
// tb_obi_mem_model: scoreboard bench for obi_mem_model (ordering, data, latency, errors, reset).
module tb_obi_mem_model;

  localparam int MAX_OUTST = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  err_rate;
  logic [3:0]  gnt_wmax;
  logic [3:0]  resp_wmax;
  logic        err_enable;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  obi_mem_model #(
    .AW_MEM(16), .DW(32), .MAX_OUTST(MAX_OUTST),
    .KEEPOUT_BASE(32'h8000_0000), .KEEPOUT_TOP(32'h8000_01ff)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ERR_RATE(err_rate), .GNT_WMAX(gnt_wmax),
    .RESP_WMAX(resp_wmax), .err_enable(err_enable), .req(req), .we(we),
    .be(be), .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          may_err;
    int          acc_cyc;
    int          pos;
  } exp_t;

  exp_t        sb[$];
  bit [31:0]   model [int];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          outst = 0;
  int          mon_cnt;
  int          lat;
  int          lat_w = 0;
  int          n_resp = 0;
  int          n_err = 0;
  bit          last_err = 1'b0;
  logic [31:0] cur_exp = '0;
  bit          cur_may_err = 1'b0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input bit cond);
    total++;
    if (!cond) begin
      bad++;
      $display("FAIL %s: got 0 expected 1 (t=%0t)", name, $time);
    end
  endtask

  // Monitor: pops responses in order, then records any grant seen this cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      outst = 0;
    end else begin
      mon_cnt = outst;
      if (rvalid) begin
        if (sb.size() == 0) begin
          chkb("unexpected_rvalid", 1'b0);
        end else begin
          mon_e = sb.pop_front();
          lat = cyc - mon_e.acc_cyc;
          chkb("latency_range", lat >= 1 && lat <= (mon_e.pos + 1) * (lat_w + 1));
          last_err = err;
          n_resp++;
          if (err) begin
            n_err++;
            chkb("err_allowed", mon_e.may_err);
            chk("err_rdata_zero", rdata, 32'h0);
          end else begin
            chk("rdata", rdata, mon_e.data);
          end
          outst--;
        end
      end else begin
        chk("idle_rdata", rdata, 32'h0);
        chk("idle_err", {31'h0, err}, 32'h0);
      end
      if (req && gnt) begin
        chkb("gnt_not_full", mon_cnt < MAX_OUTST);
        sb.push_back('{cur_exp, cur_may_err, cyc, mon_cnt});
        outst++;
      end
      chkb("outst_bound", outst <= MAX_OUTST);
    end
  end

  task automatic issue(input bit w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d,
                       input bit may_e, output int waited);
    cur_exp = exp_d;
    cur_may_err = may_e;
    we = w; be = b; addr = a; wdata = d; req = 1'b1;
    waited = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (gnt) break;
      waited++;
    end
    if (waited >= 100) chkb("gnt_timeout", 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h0000_ffff);
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old, input logic [3:0] b,
                                      input logic [31:0] d);
    bit [31:0] r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int w;
    model[widx(a)] = merge(model.exists(widx(a)) ? model[widx(a)] : 32'h0, b, d);
    issue(1'b1, b, a, d, 32'h0, 1'b0, w);
  endtask

  task automatic rd(input logic [31:0] a, input bit may_e);
    int w;
    issue(1'b0, 4'h0, a, 32'h0, model.exists(widx(a)) ? model[widx(a)] : 32'h0, may_e, w);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 5000; n++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    if (n >= 5000) chkb("drain_timeout", 1'b0);
  endtask

  task automatic wr_err(input logic [31:0] a, input logic [31:0] d);
    int w;
    issue(1'b1, 4'hf, a, d, 32'h0, 1'b1, w);
    drain();
    if (!last_err) model[widx(a)] = d;
  endtask

  initial begin
    int w;
    req = 1'b1; we = 1'b0; be = '0; addr = '0; wdata = '0;
    err_enable = 1'b0; err_rate = 3'd0; gnt_wmax = 4'd0; resp_wmax = 4'd0;
    rst_n = 1'b0;
    #1;
    chk("reset_gnt", {31'h0, gnt}, 32'h0);
    chk("reset_rvalid", {31'h0, rvalid}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; req = 1'b0;

    for (int i = 0; i < 256; i++) wr(32'(i * 4), 4'hf, 32'(i));
    drain();

    // Back-to-back reads with zero waits: granted the same cycle each time.
    issue(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, w); chk("b2b_gnt_wait0", 32'(w), 32'd0);
    issue(1'b0, 4'h0, 32'h4, 32'h0, 32'h1, 1'b0, w); chk("b2b_gnt_wait1", 32'(w), 32'd0);
    issue(1'b0, 4'h0, 32'h8, 32'h0, 32'h2, 1'b0, w); chk("b2b_gnt_wait2", 32'(w), 32'd0);
    drain();

    // Byte-masked write, read back immediately and one cycle later.
    wr(32'h10, 4'hf, 32'h1122_3344);
    wr(32'h10, 4'b0101, 32'hAABB_CCDD);
    issue(1'b0, 4'h0, 32'h10, 32'h0, 32'h11BB_33DD, 1'b0, w);
    issue(1'b0, 4'h0, 32'h10, 32'h0, 32'h11BB_33DD, 1'b0, w);
    wr(32'h14, 4'h0, 32'hFFFF_FFFF);
    issue(1'b0, 4'h0, 32'h14, 32'h0, 32'h0000_0005, 1'b0, w);
    drain();

    // Slow responses: grant must stall once four are outstanding.
    resp_wmax = 4'd15; lat_w = 15;
    for (int i = 0; i < 6; i++) rd(32'(i * 4 + 32), 1'b0);
    drain();

    // Error injection at p=1/2 outside the keepout window.
    resp_wmax = 4'd0; err_rate = 3'd7; err_enable = 1'b1;
    n_err = 0; n_resp = 0;
    for (int i = 0; i < 1000; i++) rd(32'($urandom_range(0, 255) * 4), 1'b1);
    drain();
    chk("err_resp_count", 32'(n_resp), 32'd1000);
    chkb("err_fraction", n_err >= 450 && n_err <= 550);
    n_err = 0;
    for (int i = 0; i < 1000; i++) rd(32'h8000_0000 + 32'((i % 128) * 4), 1'b0);
    drain();
    chk("keepout_errs", 32'(n_err), 32'd0);
    for (int i = 0; i < 20; i++) wr_err(32'((200 + i) * 4), 32'hDEAD_0000 + 32'(i));
    err_enable = 1'b0;
    for (int i = 0; i < 20; i++) rd(32'((200 + i) * 4), 1'b0);
    drain();

    // Random wait states with mixed traffic.
    gnt_wmax = 4'd7; resp_wmax = 4'd7;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 1)
        wr(32'($urandom_range(0, 255) * 4), 4'($urandom_range(0, 15)), 32'($urandom));
      else
        rd(32'($urandom_range(0, 255) * 4), 1'b0);
    end
    drain();

    // Reset with requests in flight: responses dropped, accepted writes kept.
    gnt_wmax = 4'd0; resp_wmax = 4'd15;
    repeat (20) @(posedge clk);
    #1;
    wr(32'h20, 4'hf, 32'hCAFE_F00D);
    wr(32'h24, 4'hf, 32'h0BAD_BEEF);
    rd(32'h28, 1'b0);
    #3;
    rst_n = 1'b0;
    req = 1'b1;
    sb.delete();
    #1;
    chk("midrst_gnt", {31'h0, gnt}, 32'h0);
    chk("midrst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_err", {31'h0, err}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    resp_wmax = 4'd0;
    rd(32'h20, 1'b0);
    rd(32'h24, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
